// File: rtl/vend_change_sequencer.sv
// Vending transaction controller: accumulates coin credit, checks the price on buy, then
// runs the dispense and coin-return handshakes. Dispenser timeout/refund: VEND_TIMEOUT_EN.
module vend_change_sequencer #(
   parameter int PRICE_A    = 40,
   parameter int PRICE_B    = 45,
   parameter int CREDIT_W   = 8,
   parameter int MAX_CREDIT = 95,
   parameter int DISP_WAIT  = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin5,
   input  logic                coin10,
   input  logic                choice,
   input  logic                buy,
   input  logic                cancel,
   output logic                goods_req,
   input  logic                goods_ack,
   output logic                coin_req,
   output logic                coin_sel,
   input  logic                coin_ack,
   output logic                coin_reject,
   output logic                err_short,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                fault
);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE, GAP} state_t;

   localparam logic [CREDIT_W-1:0] FIVE      = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] TEN       = CREDIT_W'(10);
   localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
   localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);

   if ((MAX_CREDIT % 5) != 0 || MAX_CREDIT >= (2 ** CREDIT_W) || DISP_WAIT < 1) begin : g_bad_cfg
      $error("vend_change_sequencer: illegal parameter combination");
   end

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit_nxt;
   logic [CREDIT_W-1:0] price;
   logic                goods_req_nxt, coin_req_nxt, coin_sel_nxt;
   logic                coin_reject_nxt, err_short_nxt, busy_nxt;
   logic                timeout;

   // Sum is formed one bit wider so a coin near the top of the range cannot wrap.
   function automatic logic coin_fits(input logic [CREDIT_W-1:0] cur,
                                      input logic [CREDIT_W-1:0] value);
      logic [CREDIT_W:0] sum;
      sum = {1'b0, cur} + {1'b0, value};
      return sum <= (CREDIT_W + 1)'(MAX_CREDIT);
   endfunction

   assign price = choice ? PRICE_A_C : PRICE_B_C;

`ifdef VEND_TIMEOUT_EN
   localparam int CNT_W = $clog2(DISP_WAIT + 1);

   logic [CNT_W-1:0]    wait_cnt;
   logic [CREDIT_W-1:0] price_lat;

   assign timeout = (state == VEND) && (wait_cnt == CNT_W'(DISP_WAIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         fault <= timeout && !goods_ack;
         if (state != VEND)
            wait_cnt <= '0;
         else
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // The last priced buy attempt in IDLE is the one that entered VEND.
   always_ff @(posedge clk) begin
      if (state == IDLE && buy && !cancel)
         price_lat <= price;
   end
`else
   assign timeout = 1'b0;
   assign fault   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         goods_req   <= 1'b0;
         coin_req    <= 1'b0;
         coin_sel    <= 1'b0;
         coin_reject <= 1'b0;
         err_short   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         credit      <= credit_nxt;
         goods_req   <= goods_req_nxt;
         coin_req    <= coin_req_nxt;
         coin_sel    <= coin_sel_nxt;
         coin_reject <= coin_reject_nxt;
         err_short   <= err_short_nxt;
         busy        <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cancel) begin
               if (credit != '0)
                  state_nxt = CHANGE;
            end else if (buy && credit >= price) begin
               state_nxt = VEND;
            end
         end
         VEND: begin
            if (goods_ack)
               state_nxt = (credit != '0) ? CHANGE : IDLE;
            else if (timeout)
               state_nxt = CHANGE;
         end
         CHANGE:  if (coin_ack) state_nxt = GAP;
         GAP:     state_nxt = (credit != '0) ? CHANGE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      credit_nxt      = credit;
      coin_reject_nxt = 1'b0;
      err_short_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (cancel || buy) begin
               coin_reject_nxt = coin5 || coin10;
               if (!cancel) begin
                  if (credit >= price)
                     credit_nxt = credit - price;
                  else
                     err_short_nxt = 1'b1;
               end
            end else if (coin5 && coin10) begin
               coin_reject_nxt = 1'b1;
            end else if (coin5) begin
               if (coin_fits(credit, FIVE))
                  credit_nxt = credit + FIVE;
               else
                  coin_reject_nxt = 1'b1;
            end else if (coin10) begin
               if (coin_fits(credit, TEN))
                  credit_nxt = credit + TEN;
               else
                  coin_reject_nxt = 1'b1;
            end
         end
         VEND: begin
            coin_reject_nxt = coin5 || coin10;
`ifdef VEND_TIMEOUT_EN
            if (timeout && !goods_ack)
               credit_nxt = credit + price_lat;
`endif
         end
         CHANGE: begin
            coin_reject_nxt = coin5 || coin10;
            if (coin_ack)
               credit_nxt = credit - (coin_sel ? TEN : FIVE);
         end
         default: coin_reject_nxt = coin5 || coin10;
      endcase
      goods_req_nxt = (state_nxt == VEND);
      coin_req_nxt  = (state_nxt == CHANGE);
      coin_sel_nxt  = (state_nxt == CHANGE) && (credit_nxt >= TEN);
      busy_nxt      = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_vend_change_sequencer.sv
// Bench for vend_change_sequencer: directed scenarios plus randomized IDLE traffic
// scored against a credit/price/change model written from the behavioural rules.
`timescale 1ns/1ps
module tb_vend_change_sequencer;

   localparam int PRICE_A    = 40;
   localparam int PRICE_B    = 45;
   localparam int CREDIT_W   = 8;
   localparam int MAX_CREDIT = 95;
   localparam int DISP_WAIT  = 15;

   logic clk = 1'b0, reset = 1'b0;
   logic coin5 = 1'b0, coin10 = 1'b0, choice = 1'b0, buy = 1'b0, cancel = 1'b0;
   logic goods_ack = 1'b0, coin_ack = 1'b0;
   logic goods_req, coin_req, coin_sel, coin_reject, err_short, busy, fault;
   logic [CREDIT_W-1:0] credit;

   int n_checks = 0, n_errors = 0;
   int m_credit = 0;
   int got[$], exp_q[$];
   int gap_bad, sel_bad, hung;

   vend_change_sequencer #(
      .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .CREDIT_W(CREDIT_W),
      .MAX_CREDIT(MAX_CREDIT), .DISP_WAIT(DISP_WAIT)
   ) dut (
      .clk(clk), .reset(reset), .coin5(coin5), .coin10(coin10), .choice(choice),
      .buy(buy), .cancel(cancel), .goods_req(goods_req), .goods_ack(goods_ack),
      .coin_req(coin_req), .coin_sel(coin_sel), .coin_ack(coin_ack),
      .coin_reject(coin_reject), .err_short(err_short), .credit(credit),
      .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c5, input logic c10, input logic b, input logic c, input logic ch);
      coin5 = c5; coin10 = c10; buy = b; cancel = c; choice = ch;
      tick();
      coin5 = 1'b0; coin10 = 1'b0; buy = 1'b0; cancel = 1'b0;
   endtask

   // Reference: greedy change in 10s then at most one 5.
   function automatic void plan_change(input int amt);
      exp_q.delete();
      for (int i = 0; i < amt / 10; i++) exp_q.push_back(10);
      if (amt % 10 == 5) exp_q.push_back(5);
   endfunction

   function automatic int price_of(input logic ch);
      return ch ? PRICE_A : PRICE_B;
   endfunction

   function automatic int q_sum(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   function automatic bit seq_ok();
      if (got.size() != exp_q.size()) return 1'b0;
      foreach (got[i]) if (got[i] != exp_q[i]) return 1'b0;
      return (gap_bad == 0) && (sel_bad == 0) && (hung == 0);
   endfunction

   task automatic load_credit(input int target);
      while (m_credit < target) begin
         if (target - m_credit >= 10 && $urandom_range(0, 1) == 1) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            m_credit += 10;
         end else begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            m_credit += 5;
         end
      end
   endtask

   task automatic serve_goods(input int delay);
      repeat (delay) tick();
      goods_ack = 1'b1;
      tick();
      goods_ack = 1'b0;
   endtask

   // Hopper responder: acks each coin request after a random delay and logs the coin.
   task automatic collect_change();
      int   budget;
      logic sel0;
      budget = 600; got.delete(); gap_bad = 0; sel_bad = 0; hung = 0;
      while (busy === 1'b1 && budget > 0) begin
         if (coin_req === 1'b1) begin
            sel0 = coin_sel;
            repeat ($urandom_range(0, 3)) begin
               tick(); budget--;
               if (coin_sel !== sel0 || coin_req !== 1'b1) sel_bad++;
            end
            got.push_back(sel0 ? 10 : 5);
            coin_ack = 1'b1; tick(); coin_ack = 1'b0; budget--;
            if (coin_req !== 1'b0) gap_bad++;
         end else begin
            tick(); budget--;
         end
      end
      if (budget <= 0) hung = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1; coin5 = 1'b1; coin10 = 1'b1; buy = 1'b1; cancel = 1'b1;
      goods_ack = 1'b1; coin_ack = 1'b1;
      tick(); tick();
      coin5 = 1'b0; coin10 = 1'b0; buy = 1'b0; cancel = 1'b0; goods_ack = 1'b0; coin_ack = 1'b0;
      n_checks++;
      if ({goods_req, coin_req, coin_sel, coin_reject, err_short, busy, fault} !== 7'b0 || credit !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got flags=%b credit=%0d, expected flags=0000000 credit=0",
                  {goods_req, coin_req, coin_sel, coin_reject, err_short, busy, fault}, credit);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if ({goods_req, coin_req, busy, fault} !== 4'b0 || credit !== '0) begin
         n_errors++;
         $display("FAIL reset_release: got flags=%b credit=%0d, expected flags=0000 credit=0",
                  {goods_req, coin_req, busy, fault}, credit);
      end
      m_credit = 0;
   endtask

   task automatic test_purchase();
      int vals[5] = '{10, 10, 10, 10, 5};
      foreach (vals[i]) begin
         drive(vals[i] == 5, vals[i] == 10, 1'b0, 1'b0, 1'b0);
         m_credit += vals[i];
         n_checks++;
         if (credit !== CREDIT_W'(m_credit) || coin_reject !== 1'b0) begin
            n_errors++;
            $display("FAIL t1_coin%0d: got credit=%0d rej=%b, expected credit=%0d rej=0",
                     i, credit, coin_reject, m_credit);
         end
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      m_credit -= price_of(1'b1);
      n_checks++;
      if (goods_req !== 1'b1 || busy !== 1'b1 || credit !== CREDIT_W'(m_credit)) begin
         n_errors++;
         $display("FAIL t1_buy: got goods_req=%b busy=%b credit=%0d, expected 1 1 %0d",
                  goods_req, busy, credit, m_credit);
      end
      serve_goods($urandom_range(0, 4));
      n_checks++;
      if (goods_req !== 1'b0) begin
         n_errors++;
         $display("FAIL t1_goods_drop: got goods_req=%b, expected 0", goods_req);
      end
      plan_change(m_credit);
      collect_change();
      m_credit = 0;
      n_checks++;
      if (!seq_ok()) begin
         n_errors++;
         $display("FAIL t1_change: got %0d coins sum %0d gap_bad %0d sel_bad %0d hung %0d, expected %0d coins sum %0d",
                  got.size(), q_sum(got), gap_bad, sel_bad, hung, exp_q.size(), q_sum(exp_q));
      end
      n_checks++;
      if (credit !== '0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL t1_idle: got credit=%0d busy=%b, expected 0 0", credit, busy);
      end
   endtask

   task automatic test_short_cancel();
      load_credit(30);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (err_short !== 1'b1 || credit !== CREDIT_W'(30) || busy !== 1'b0 || goods_req !== 1'b0) begin
         n_errors++;
         $display("FAIL t2_short: got err=%b credit=%0d busy=%b greq=%b, expected 1 30 0 0",
                  err_short, credit, busy, goods_req);
      end
      tick();
      n_checks++;
      if (err_short !== 1'b0) begin
         n_errors++;
         $display("FAIL t2_short_pulse: got err_short=%b one cycle later, expected 0", err_short);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      plan_change(m_credit);
      collect_change();
      m_credit = 0;
      n_checks++;
      if (!seq_ok() || credit !== '0) begin
         n_errors++;
         $display("FAIL t2_change: got %0d coins sum %0d gap_bad %0d sel_bad %0d hung %0d credit %0d, expected %0d coins sum %0d credit 0",
                  got.size(), q_sum(got), gap_bad, sel_bad, hung, credit, exp_q.size(), q_sum(exp_q));
      end
   endtask

   task automatic test_overflow();
      load_credit(90);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (coin_reject !== 1'b1 || credit !== CREDIT_W'(90)) begin
         n_errors++;
         $display("FAIL t3_over10: got rej=%b credit=%0d, expected 1 90", coin_reject, credit);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      m_credit = 95;
      n_checks++;
      if (coin_reject !== 1'b0 || credit !== CREDIT_W'(95)) begin
         n_errors++;
         $display("FAIL t3_fill5: got rej=%b credit=%0d, expected 0 95", coin_reject, credit);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (coin_reject !== 1'b1 || credit !== CREDIT_W'(95)) begin
         n_errors++;
         $display("FAIL t3_both: got rej=%b credit=%0d, expected 1 95", coin_reject, credit);
      end
   endtask

   task automatic test_max_buy();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      m_credit -= price_of(1'b0);
      n_checks++;
      if (goods_req !== 1'b1 || credit !== CREDIT_W'(m_credit)) begin
         n_errors++;
         $display("FAIL t4_buy: got greq=%b credit=%0d, expected 1 %0d", goods_req, credit, m_credit);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (coin_reject !== 1'b1 || credit !== CREDIT_W'(m_credit) || goods_req !== 1'b1) begin
         n_errors++;
         $display("FAIL t4_vend_coin: got rej=%b credit=%0d greq=%b, expected 1 %0d 1",
                  coin_reject, credit, goods_req, m_credit);
      end
      serve_goods($urandom_range(0, 4));
      plan_change(m_credit);
      collect_change();
      m_credit = 0;
      n_checks++;
      if (!seq_ok() || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL t4_change: got %0d coins sum %0d gap_bad %0d sel_bad %0d hung %0d, expected %0d coins sum %0d",
                  got.size(), q_sum(got), gap_bad, sel_bad, hung, exp_q.size(), q_sum(exp_q));
      end
   endtask

   task automatic test_reset_mid_change();
      load_credit(20);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (coin_req !== 1'b1 || coin_sel !== 1'b1) begin
         n_errors++;
         $display("FAIL t5_in_change: got coin_req=%b sel=%b, expected 1 1", coin_req, coin_sel);
      end
      reset = 1'b1; coin5 = 1'b1;
      tick();
      reset = 1'b0; coin5 = 1'b0;
      m_credit = 0;
      n_checks++;
      if ({goods_req, coin_req, coin_sel, coin_reject, err_short, busy, fault} !== 7'b0 || credit !== '0) begin
         n_errors++;
         $display("FAIL t5_reset: got flags=%b credit=%0d, expected flags=0000000 credit=0",
                  {goods_req, coin_req, coin_sel, coin_reject, err_short, busy, fault}, credit);
      end
      coin_ack = 1'b1; tick(); coin_ack = 1'b0;
      n_checks++;
      if (coin_req !== 1'b0 || busy !== 1'b0 || credit !== '0) begin
         n_errors++;
         $display("FAIL t5_late_ack: got coin_req=%b busy=%b credit=%0d, expected 0 0 0",
                  coin_req, busy, credit);
      end
   endtask

   task automatic test_timeout();
      int hi;
      load_credit(40);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      m_credit -= price_of(1'b1);
`ifdef VEND_TIMEOUT_EN
      hi = 0;
      while (goods_req === 1'b1 && hi < 200) begin
         hi++;
         tick();
      end
      n_checks++;
      if (hi != DISP_WAIT || fault !== 1'b1 || credit !== CREDIT_W'(40)) begin
         n_errors++;
         $display("FAIL t6_timeout: got req_cycles=%0d fault=%b credit=%0d, expected %0d 1 40",
                  hi, fault, credit, DISP_WAIT);
      end
      m_credit = 40;
      plan_change(m_credit);
      collect_change();
      m_credit = 0;
      n_checks++;
      if (!seq_ok() || fault !== 1'b0) begin
         n_errors++;
         $display("FAIL t6_refund: got %0d coins sum %0d gap_bad %0d sel_bad %0d hung %0d fault %b, expected %0d coins sum %0d fault 0",
                  got.size(), q_sum(got), gap_bad, sel_bad, hung, fault, exp_q.size(), q_sum(exp_q));
      end
`else
      hi = 0;
      repeat (100) tick();
      n_checks++;
      if (goods_req !== 1'b1 || fault !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL t6_no_timeout: got greq=%b fault=%b busy=%b after 100 cycles, expected 1 0 1",
                  goods_req, fault, busy);
      end
      serve_goods(0);
      n_checks++;
      if (goods_req !== 1'b0 || busy !== 1'b0 || credit !== '0) begin
         n_errors++;
         $display("FAIL t6_late_ack: got greq=%b busy=%b credit=%0d, expected 0 0 0",
                  goods_req, busy, credit);
      end
`endif
   endtask

   task automatic test_random();
      for (int op = 0; op < 60; op++) begin
         logic c5, c10, b, c, ch;
         int   r, price, exp_rej, exp_err, want_vend, want_change;
         c5 = 1'b0; c10 = 1'b0; b = 1'b0; c = 1'b0;
         ch = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 99));
         if (r < 35) c5 = 1'b1;
         else if (r < 70) c10 = 1'b1;
         else if (r < 76) begin c5 = 1'b1; c10 = 1'b1; end
         else if (r < 92) b = 1'b1;
         else c = 1'b1;
         if ((b || c) && $urandom_range(0, 3) == 0) c5 = 1'b1;
         exp_rej = 0; exp_err = 0; want_vend = 0; want_change = 0;
         if (c) begin
            exp_rej = int'(c5 | c10);
            want_change = int'(m_credit > 0);
         end else if (b) begin
            exp_rej = int'(c5 | c10);
            price = price_of(ch);
            if (m_credit >= price) begin
               m_credit -= price;
               want_vend = 1;
            end else begin
               exp_err = 1;
            end
         end else if (c5 && c10) begin
            exp_rej = 1;
         end else if (c5) begin
            if (m_credit + 5 <= MAX_CREDIT) m_credit += 5; else exp_rej = 1;
         end else if (c10) begin
            if (m_credit + 10 <= MAX_CREDIT) m_credit += 10; else exp_rej = 1;
         end
         goods_ack = 1'($urandom_range(0, 7) == 0);
         coin_ack  = 1'($urandom_range(0, 7) == 0);
         drive(c5, c10, b, c, ch);
         goods_ack = 1'b0; coin_ack = 1'b0;
         n_checks++;
         if ({coin_reject, err_short, goods_req, coin_req} !== {1'(exp_rej), 1'(exp_err), 1'(want_vend), 1'(want_change)}
             || credit !== CREDIT_W'(m_credit)) begin
            n_errors++;
            $display("FAIL rand_op%0d: got rej=%b err=%b greq=%b creq=%b credit=%0d, expected rej=%0d err=%0d greq=%0d creq=%0d credit=%0d",
                     op, coin_reject, err_short, goods_req, coin_req, credit,
                     exp_rej, exp_err, want_vend, want_change, m_credit);
         end
         if (want_vend != 0 || want_change != 0) begin
            if (want_vend != 0) serve_goods($urandom_range(0, 4));
            plan_change(m_credit);
            collect_change();
            m_credit = 0;
            n_checks++;
            if (!seq_ok() || credit !== '0 || busy !== 1'b0) begin
               n_errors++;
               $display("FAIL rand_op%0d_change: got %0d coins sum %0d gap_bad %0d sel_bad %0d hung %0d credit %0d, expected %0d coins sum %0d credit 0",
                        op, got.size(), q_sum(got), gap_bad, sel_bad, hung, credit, exp_q.size(), q_sum(exp_q));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_purchase();
      test_short_cancel();
      test_overflow();
      test_max_buy();
      test_reset_mid_change();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
